instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch-side front end that produces the 2-bit opcode and register/immediate fields consumed by the main control decoder.
//  Holds the PC and issues word reads to instruction memory over a variable-latency req/valid interface.
//  Presents one instruction at a time to the datapath over a valid/ready handshake.
//  Redirects the PC on a taken branch (Branch & ALU zero), which is reported back when the beq is accepted.
// PARAMETERS
//  PC_W     8     PC / instruction-memory word-address width
//  INSTR_W  16    instruction width; fields below fixed for 16
//  RESET_PC 0     PC value loaded on reset
// PORTS
//  clk            in   1        rising-edge clock
//  rst_n          in   1        asynchronous active-low reset
//  imem_req       out  1        read request, held until imem_valid
//  imem_addr      out  PC_W     word address, stable while imem_req=1
//  imem_valid     in   1        rdata valid this cycle; ignored unless request outstanding
//  imem_rdata     in   INSTR_W  instruction word
//  instr_valid    out  1        instruction fields valid
//  instr_ready    in   1        datapath accepts current instruction
//  opcode         out  2        instr[15:14], to main control
//  rs/rt/rd       out  3 each   instr[13:11] / [10:8] / [7:5]
//  imm8           out  8        instr[7:0]
//  pc_plus1       out  PC_W     address of accepted-instruction + 1
//  branch_taken   in   1        sampled only on accept cycle (instr_valid&instr_ready)
//  halt           in   1        stop issuing new requests while 1
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=REQ_IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, fields/pc_plus1=0.
//  - FSM: IDLE -> REQ (halt=0) -> WAIT (imem_req=1) -> HOLD on imem_valid -> IDLE on accept.
//    IDLE: imem_req=0; if !halt go REQ next cycle. REQ/WAIT merged in RTL is allowed if the timing below holds.
//    WAIT: imem_req=1, imem_addr=pc; on imem_valid latch rdata into instruction register, instr_valid=1 next cycle.
//    HOLD: instr_valid=1, outputs frozen until instr_ready=1.
//  - Min latency: first instr_valid 2 cycles after rst_n release with imem_valid returned the cycle after req.
//  - Accept (instr_valid&instr_ready): pc <= branch_taken ? pc+1+sext(imm8) : pc+1, PC_W wrap-around (mod 2^PC_W);
//    if !halt, imem_req asserted the cycle after accept (one bubble per instruction; no prefetch).
//  - Branch target arithmetic: imm8 sign-extended/truncated to PC_W; overflow wraps silently.
//  - branch_taken outside an accept cycle has no effect; taken on non-beq opcode is still honoured (control owns correctness).
//  - halt asserted while request outstanding: complete the request and hold the instruction; no new request until halt=0.
//  - imem_valid while no request outstanding: ignored, no state change.
//  - Reset mid-request: request dropped immediately, late imem_valid after reset ignored until a new req is issued.
//  - instr_ready with instr_valid=0: no effect.
// STRUCTURE
//  - Shared package: INSTR_W, field bit positions, opcode constants OP_RTYPE=2'b00, OP_LW=2'b01, OP_SW=2'b10, OP_BEQ=2'b11,
//    FSM state encoding (IDLE/REQ/WAIT/HOLD).
//  - One sub-module: pc_next_calc (combinational pc+1 and branch target with sign extension).
// TESTING
//  1 Reset then imem_valid 1 cycle after req, rdata=16'h4123 -> addr 0 requested; opcode=2'b01, rs=0, rt=1, rd=1, imm8=8'h23, pc_plus1=1.
//  2 Hold instr_ready=0 for 5 cycles -> all fields and instr_valid stable, imem_req=0; accept -> next imem_addr=1.
//  3 beq at pc=4 with imm8=8'hFD, branch_taken=1 on accept -> next imem_addr=2 (4+1-3); with branch_taken=0 -> 5.
//  4 pc=255 (PC_W=8), not taken -> next imem_addr=0 (wrap).
//  5 imem_valid delayed 3 cycles -> imem_req and imem_addr held; spurious imem_valid while idle/halted -> ignored.
//  6 rst_n pulsed low during WAIT -> imem_req=0, instr_valid=0 immediately; refetch starts from RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit_pkg
//  Description : Shared constants, instruction field positions, opcodes and
//                fetch FSM state encoding for the instruction fetch unit.
//  Revision    : 1.0  initial release
// ============================================================================
package instr_fetch_unit_pkg;

    localparam int c_INSTR_W = 16;

    localparam int c_OPC_MSB = 15;
    localparam int c_OPC_LSB = 14;
    localparam int c_RS_MSB  = 13;
    localparam int c_RS_LSB  = 11;
    localparam int c_RT_MSB  = 10;
    localparam int c_RT_LSB  = 8;
    localparam int c_RD_MSB  = 7;
    localparam int c_RD_LSB  = 5;
    localparam int c_IMM_MSB = 7;
    localparam int c_IMM_LSB = 0;

    localparam logic [1:0] OP_RTYPE = 2'b00;
    localparam logic [1:0] OP_LW    = 2'b01;
    localparam logic [1:0] OP_SW    = 2'b10;
    localparam logic [1:0] OP_BEQ   = 2'b11;

    // REQ_SEND is the first request cycle, REQ_WAIT any further ones.
    typedef enum logic [1:0] {
        REQ_IDLE = 2'd0,
        REQ_SEND = 2'd1,
        REQ_WAIT = 2'd2,
        REQ_HOLD = 2'd3
    } fetch_state_e;

endpackage : instr_fetch_unit_pkg
`default_nettype wire

// File: rtl/instr_fetch_unit_pc_next_calc.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_calc
//  Description : Combinational sequential-PC and branch-target computation
//                (pc+1 and pc+1+sext(imm8), both modulo 2^PC_W).
//  Revision    : 1.0  initial release
// ============================================================================
module pc_next_calc #(
    parameter int PC_W = 8
) (
    input  logic [PC_W-1:0] i_pc,
    input  logic [7:0]      i_imm8,
    input  logic            i_taken,
    output logic [PC_W-1:0] o_pc_plus1,
    output logic [PC_W-1:0] o_pc_next
);

    logic [PC_W-1:0] w_offset;
    logic [PC_W-1:0] w_target;

    // Offset is sign-extended for wide PCs and truncated for narrow ones.
    if (PC_W > 8) begin : g_sext
        assign w_offset = {{(PC_W-8){i_imm8[7]}}, i_imm8};
    end else if (PC_W == 8) begin : g_same
        assign w_offset = i_imm8;
    end else begin : g_trunc
        assign w_offset = i_imm8[PC_W-1:0];
    end

    assign o_pc_plus1 = i_pc + PC_W'(1);
    assign w_target   = o_pc_plus1 + w_offset;
    assign o_pc_next  = i_taken ? w_target : o_pc_plus1;

endmodule : pc_next_calc
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : PC holder and single-outstanding instruction fetcher feeding
//                decoded fields to the datapath over valid/ready.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int          PC_W     = 8,
    parameter int          INSTR_W  = c_INSTR_W,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [1:0]         opcode,
    output logic [2:0]         rs,
    output logic [2:0]         rt,
    output logic [2:0]         rd,
    output logic [7:0]         imm8,
    output logic [PC_W-1:0]    pc_plus1,
    input  logic               branch_taken,
    input  logic               halt
);

    fetch_state_e       r_state;
    fetch_state_e       w_state_nxt;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    r_pc_plus1;
    logic [INSTR_W-1:0] r_instr;
    logic               w_load;
    logic               w_accept;
    logic [PC_W-1:0]    w_pc_plus1;
    logic [PC_W-1:0]    w_pc_next;

    pc_next_calc #(
        .PC_W (PC_W)
    ) u_pc_next_calc (
        .i_pc       (r_pc),
        .i_imm8     (r_instr[c_IMM_MSB:c_IMM_LSB]),
        .i_taken    (branch_taken),
        .o_pc_plus1 (w_pc_plus1),
        .o_pc_next  (w_pc_next)
    );

    assign w_accept = (r_state == REQ_HOLD) && instr_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (r_state)
            REQ_IDLE: begin
                if (!halt) begin
                    w_state_nxt = REQ_SEND;
                end
            end
            REQ_SEND, REQ_WAIT: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = REQ_HOLD;
                end else begin
                    w_state_nxt = REQ_WAIT;
                end
            end
            REQ_HOLD: begin
                instr_valid = 1'b1;
                // Issue the next request straight from accept to keep one bubble.
                if (instr_ready) begin
                    w_state_nxt = halt ? REQ_IDLE : REQ_SEND;
                end
            end
            default: begin
                w_state_nxt = REQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= REQ_IDLE;
            r_pc       <= PC_W'(RESET_PC);
            r_instr    <= '0;
            r_pc_plus1 <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_instr    <= imem_rdata;
                r_pc_plus1 <= w_pc_plus1;
            end
            if (w_accept) begin
                r_pc <= w_pc_next;
            end
        end
    end

    assign imem_addr = r_pc;
    assign opcode    = r_instr[c_OPC_MSB:c_OPC_LSB];
    assign rs        = r_instr[c_RS_MSB:c_RS_LSB];
    assign rt        = r_instr[c_RT_MSB:c_RT_LSB];
    assign rd        = r_instr[c_RD_MSB:c_RD_LSB];
    assign imm8      = r_instr[c_IMM_MSB:c_IMM_LSB];
    assign pc_plus1  = r_pc_plus1;

endmodule : instr_fetch_unit
`default_nettype wire
